// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and registers
// fetched words into IF/ID; a RUN/DRAIN/HALTED machine freezes fetch on halt.
module fetch_stage #(
  parameter int               PC_W      = 9,
  parameter int               INS_W     = 32,
  parameter int               RESET_PC  = 0,
  parameter int               DRAIN_CYC = 3,
  parameter logic [INS_W-1:0] NOP       = 32'h00000013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt_id,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [PC_W-1:0]  imem_addr,
  output logic [PC_W-1:0]  if_id_pc,
  output logic [PC_W-1:0]  if_id_pc4,
  output logic [INS_W-1:0] if_id_instr,
  output logic             if_id_valid,
  output logic             halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int              CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [PC_W-1:0]  PC_ALIGN = {{(PC_W-2){1'b1}}, 2'b00};
  localparam logic [PC_W-1:0]  PC_RST   = PC_W'(RESET_PC);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   drain_cnt_r, drain_cnt_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic [PC_W-1:0]    pc_plus4_s;
  logic [PC_W-1:0]    if_id_pc_r, if_id_pc_s;
  logic [PC_W-1:0]    if_id_pc4_r, if_id_pc4_s;
  logic [INS_W-1:0]   if_id_instr_r, if_id_instr_s;
  logic               if_id_valid_r, if_id_valid_s;
  logic               halted_r, halted_s;

  assign pc_plus4_s = pc_r + PC_W'(4);

  // Next-state and next-register selection for the fetch/halt machine.
  always_comb begin
    state_s       = state_r;
    drain_cnt_s   = drain_cnt_r;
    pc_s          = pc_r;
    if_id_pc_s    = if_id_pc_r;
    if_id_pc4_s   = if_id_pc4_r;
    if_id_instr_s = if_id_instr_r;
    if_id_valid_s = if_id_valid_r;
    halted_s      = halted_r;
    case (state_r)
      RUN: begin
        if (redirect_valid) begin
          // A younger halt in ID is squashed by the redirect, so stay in RUN.
          pc_s          = redirect_pc & PC_ALIGN;
          if_id_pc_s    = {PC_W{1'b0}};
          if_id_pc4_s   = {PC_W{1'b0}};
          if_id_instr_s = NOP;
          if_id_valid_s = 1'b0;
        end else if (halt_id && if_id_valid_r) begin
          if_id_pc_s    = {PC_W{1'b0}};
          if_id_pc4_s   = {PC_W{1'b0}};
          if_id_instr_s = NOP;
          if_id_valid_s = 1'b0;
          drain_cnt_s   = {CNT_W{1'b0}};
          state_s       = DRAIN;
        end else if (stall) begin
          pc_s = pc_r;
        end else begin
          pc_s          = pc_plus4_s;
          if_id_pc_s    = pc_r;
          if_id_pc4_s   = pc_plus4_s;
          if_id_instr_s = imem_rdata;
          if_id_valid_s = 1'b1;
        end
      end
      DRAIN: begin
        drain_cnt_s = drain_cnt_r + CNT_W'(1);
        if (drain_cnt_r == CNT_LAST) begin
          state_s  = HALTED;
          halted_s = 1'b1;
        end else begin
          halted_s = 1'b0;
        end
      end
      HALTED: begin
        halted_s = 1'b1;
      end
      default: begin
        state_s  = RUN;
        halted_s = 1'b0;
      end
    endcase
  end

  // State and pipeline-register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      drain_cnt_r   <= {CNT_W{1'b0}};
      pc_r          <= PC_RST;
      if_id_pc_r    <= {PC_W{1'b0}};
      if_id_pc4_r   <= {PC_W{1'b0}};
      if_id_instr_r <= NOP;
      if_id_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      drain_cnt_r   <= drain_cnt_s;
      pc_r          <= pc_s;
      if_id_pc_r    <= if_id_pc_s;
      if_id_pc4_r   <= if_id_pc4_s;
      if_id_instr_r <= if_id_instr_s;
      if_id_valid_r <= if_id_valid_s;
      halted_r      <= halted_s;
    end
  end

  assign imem_addr   = pc_r;
  assign if_id_pc    = if_id_pc_r;
  assign if_id_pc4   = if_id_pc4_r;
  assign if_id_instr = if_id_instr_r;
  assign if_id_valid = if_id_valid_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued as each
// cycle is driven and compared after the edge; PC and halted checked directly.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        halt_id;
  logic [31:0] imem_rdata;
  logic [8:0]  imem_addr;
  logic [8:0]  if_id_pc;
  logic [8:0]  if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;

  typedef struct packed {
    logic [8:0]  pc;
    logic [8:0]  pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  ifid_t      exp_q[$];
  ifid_t      last_ifid;
  logic [8:0] exp_pc;
  int         checks = 0;
  int         errors = 0;

  fetch_stage #(
    .PC_W(9), .INS_W(32), .RESET_PC(0), .DRAIN_CYC(3), .NOP(32'h00000013)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_id(halt_id), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_rdata = 32'hA0 + {23'd0, imem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch();
    ifid_t e;
    e.pc    = exp_pc;
    e.pc4   = exp_pc + 9'd4;
    e.instr = 32'hA0 + {23'd0, exp_pc};
    e.valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_bubble();
    ifid_t e;
    e.pc    = 9'd0;
    e.pc4   = 9'd0;
    e.instr = NOP;
    e.valid = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_hold();
    exp_q.push_back(last_ifid);
  endtask

  task automatic pop_chk(input string tag);
    ifid_t e;
    chk({tag, "_qnonempty"}, {31'd0, exp_q.size() > 0}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_pc"},    {23'd0, if_id_pc},  {23'd0, e.pc});
      chk({tag, "_pc4"},   {23'd0, if_id_pc4}, {23'd0, e.pc4});
      chk({tag, "_instr"}, if_id_instr,        e.instr);
      chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
      last_ifid = e;
    end
  endtask

  task automatic adv(input string tag);
    push_fetch();
    tick();
    exp_pc = exp_pc + 9'd4;
    chk({tag, "_addr"}, {23'd0, imem_addr}, {23'd0, exp_pc});
    pop_chk(tag);
  endtask

  task automatic hold(input string tag, input logic exp_halted);
    push_hold();
    tick();
    chk({tag, "_addr"},   {23'd0, imem_addr}, {23'd0, exp_pc});
    chk({tag, "_halted"}, {31'd0, halted},    {31'd0, exp_halted});
    pop_chk(tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 9'd0; halt_id = 1'b0;
    exp_pc = 9'd0;
    tick();
    push_bubble();
    tick();
    chk("rst_addr", {23'd0, imem_addr}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    pop_chk("rst");
    reset = 1'b0;

    // Free-running fetch
    adv("run0");
    adv("run1");

    // Stall holds PC=8 and IF/ID pc=4
    stall = 1'b1;
    hold("stall0", 1'b0);
    hold("stall1", 1'b0);
    stall = 1'b0;
    adv("resume0");
    adv("resume1");

    // Redirect wins over stall, target aligned
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h047;
    push_bubble();
    tick();
    exp_pc = 9'h044;
    chk("redir_addr", {23'd0, imem_addr}, {23'd0, exp_pc});
    pop_chk("redir");
    stall = 1'b0; redirect_valid = 1'b0;

    // Halt with a bubble in ID is ignored
    halt_id = 1'b1;
    adv("halt_bubble_ignored");
    halt_id = 1'b0;
    chk("halt_ignored_halted", {31'd0, halted}, 32'd0);
    adv("run2");

    // Halt and redirect together: redirect taken, stays in RUN
    halt_id = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h1FD;
    push_bubble();
    tick();
    exp_pc = 9'h1FC;
    chk("hr_addr", {23'd0, imem_addr}, {23'd0, exp_pc});
    chk("hr_halted", {31'd0, halted}, 32'd0);
    pop_chk("hr");
    halt_id = 1'b0; redirect_valid = 1'b0;

    // PC wraps from 0x1FC to 0
    adv("wrap");
    chk("wrap_halted", {31'd0, halted}, 32'd0);

    // Halt with stall still transitions; halted rises 3 edges later
    halt_id = 1'b1; stall = 1'b1;
    push_bubble();
    tick();
    chk("halt_addr", {23'd0, imem_addr}, {23'd0, exp_pc});
    chk("halt_halted", {31'd0, halted}, 32'd0);
    pop_chk("halt");
    halt_id = 1'b0; stall = 1'b0;
    hold("drain1", 1'b0);
    redirect_valid = 1'b1; redirect_pc = 9'h0AA;
    hold("drain2_redir_ignored", 1'b0);
    redirect_valid = 1'b0;
    hold("drain3", 1'b1);
    hold("halted_frozen0", 1'b1);
    redirect_valid = 1'b1;
    hold("halted_frozen1", 1'b1);
    redirect_valid = 1'b0;

    // Reset from HALTED
    reset = 1'b1;
    push_bubble();
    tick();
    exp_pc = 9'd0;
    chk("rst2_addr", {23'd0, imem_addr}, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    pop_chk("rst2");
    reset = 1'b0;
    adv("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
